// File: rtl/axi_mem_pkg.sv
// Shared encodings for the HLS memory arbiter: FSM states, response error codes and
// the watchdog counter width helper.
package axi_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// Bundle of requester-side and handler-side signals around axi_mem_arbiter.
// slave = the arbiter's view; master = the surrounding datapath/handlers.
interface axi_mem_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic                          resp_err;
  logic                          busy;
  logic                          rd_start;
  logic [ADDR_WIDTH-1:0]         rd_addr;
  logic                          rd_ready;
  logic                          rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          wr_start;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          wr_ready;
  logic                          wr_valid;

  modport slave (
    input  req, req_we, req_addr, req_wdata, rd_ready, rd_valid, rd_data, wr_ready, wr_valid,
    output req_ack, resp_valid, resp_rdata, resp_err, busy,
           rd_start, rd_addr, wr_start, wr_addr, wr_data
  );

  modport master (
    output req, req_we, req_addr, req_wdata, rd_ready, rd_valid, rd_data, wr_ready, wr_valid,
    input  req_ack, resp_valid, resp_rdata, resp_err, busy,
           rd_start, rd_addr, wr_start, wr_addr, wr_data
  );

endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: first eligible requester scanning ptr, ptr+1, ... mod N.
module rr_arbiter_n #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && eligible[cand]) begin
        grant[cand] = 1'b1;
        idx         = IW'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Round-robin sharing of one AXI-lite read handler and one write handler between
// NUM_REQ HLS load/store units, with a per-access watchdog and one response per request.
module axi_mem_arbiter
  import axi_mem_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 256
) (
  input  logic             clk,
  input  logic             rst,
  axi_mem_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic                  we_q, we_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d, resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wr_data_q, wr_data_d;
  logic                  err_q, err_d, busy_q, busy_d;
  logic                  rd_start_q, rd_start_d, wr_start_q, wr_start_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  logic [NUM_REQ-1:0]    eligible, grant;
  logic [IW-1:0]         win_idx;
  logic                  win_any;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // A requester only competes when the handler it needs can take a new access.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = bus.req[i] & (bus.req_we[i] ? bus.wr_ready : bus.rd_ready);
  end

  rr_arbiter_n #(.N(NUM_REQ), .IW(IW)) u_rr (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .idx      (win_idx),
    .any      (win_any)
  );

  assign win_addr  = bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];

  // Registered outputs are computed for the state being entered, so they line up with it.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    resp_valid_d = '0;
    rd_start_d   = 1'b0;
    wr_start_d   = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_ISSUE;
          owner_d = win_idx;
          we_d    = bus.req_we[win_idx];
          ack_d   = grant;
          if (bus.req_we[win_idx]) begin
            wr_start_d = 1'b1;
            wr_addr_d  = win_addr;
            wr_data_d  = win_wdata;
          end else begin
            rd_start_d = 1'b1;
            rd_addr_d  = win_addr;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A valid on the last counted cycle still completes the access cleanly.
        if (we_q ? bus.wr_valid : bus.rd_valid) begin
          rdata_d      = we_q ? '0 : bus.rd_data;
          err_d        = ERR_NONE;
          resp_valid_d = NUM_REQ'(1) << owner_q;
          state_d      = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d      = '0;
          err_d        = ERR_TIMEOUT;
          resp_valid_d = NUM_REQ'(1) << owner_q;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      ack_q        <= '0;
      resp_valid_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      rd_start_q   <= 1'b0;
      wr_start_q   <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      rd_start_q   <= rd_start_d;
      wr_start_q   <= wr_start_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_q;
  assign bus.rd_start   = rd_start_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.wr_start   = wr_start_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: a table of single accesses plus hand-written
// timeout and mid-access reset sequences; the bench plays both requesters and handlers.
module tb_axi_mem_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int TIMEOUT    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_mem_arbiter_if #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) bus ();

  axi_mem_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        rdy_r;
    logic        rdy_w;
    int          dly;        // cycles from start pulse to handler valid (>=1)
    logic [31:0] hdata;      // data the read handler returns
    logic [1:0]  exp_ack;
    logic        exp_rd;     // 1: load expected, 0: store expected
    logic [4:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(
    input logic [1:0] req, input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
    input logic [31:0] wd0, input logic [31:0] wd1, input logic rdy_r, input logic rdy_w,
    input int dly, input logic [31:0] hdata, input logic [1:0] exp_ack, input logic exp_rd,
    input logic [4:0] exp_addr, input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
    v.rdy_r = rdy_r; v.rdy_w = rdy_w; v.dly = dly; v.hdata = hdata;
    v.exp_ack = exp_ack; v.exp_rd = exp_rd; v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ack"},      32'(bus.req_ack),    32'h0);
    check({tag, " resp"},     32'(bus.resp_valid), 32'h0);
    check({tag, " rdata"},    bus.resp_rdata,      32'h0);
    check({tag, " err"},      32'(bus.resp_err),   32'h0);
    check({tag, " busy"},     32'(bus.busy),       32'h0);
    check({tag, " rd_start"}, 32'(bus.rd_start),   32'h0);
    check({tag, " wr_start"}, 32'(bus.wr_start),   32'h0);
    check({tag, " rd_addr"},  32'(bus.rd_addr),    32'h0);
    check({tag, " wr_addr"},  32'(bus.wr_addr),    32'h0);
    check({tag, " wr_data"},  bus.wr_data,         32'h0);
  endtask

  // One complete access: request, handler valid after v.dly cycles, exact response timing.
  task automatic run_vec(input int id, input vec_t v);
    bit got;
    bus.req       = v.req;
    bus.req_we    = v.we;
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.wd1, v.wd0};
    bus.rd_ready  = v.rdy_r;
    bus.wr_ready  = v.rdy_w;
    bus.rd_data   = v.hdata;
    bus.rd_valid  = 1'b0;
    bus.wr_valid  = 1'b0;
    wait_ack(got);
    check($sformatf("v%0d ack_seen", id), 32'(got), 32'h1);
    if (!got) return;
    check($sformatf("v%0d ack", id),      32'(bus.req_ack),  32'(v.exp_ack));
    check($sformatf("v%0d rd_start", id), 32'(bus.rd_start), 32'(v.exp_rd));
    check($sformatf("v%0d wr_start", id), 32'(bus.wr_start), 32'(!v.exp_rd));
    check($sformatf("v%0d busy", id),     32'(bus.busy),     32'h1);
    if (v.exp_rd) begin
      check($sformatf("v%0d rd_addr", id), 32'(bus.rd_addr), 32'(v.exp_addr));
    end else begin
      check($sformatf("v%0d wr_addr", id), 32'(bus.wr_addr), 32'(v.exp_addr));
      check($sformatf("v%0d wr_data", id), bus.wr_data,      v.exp_wdata);
    end
    bus.req = bus.req & ~bus.req_ack;
    @(negedge clk);
    check($sformatf("v%0d ack_once", id),   32'(bus.req_ack),              32'h0);
    check($sformatf("v%0d start_once", id), 32'(bus.rd_start | bus.wr_start), 32'h0);
    repeat (v.dly - 1) @(negedge clk);
    if (v.exp_rd) bus.rd_valid = 1'b1;
    else          bus.wr_valid = 1'b1;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    bus.wr_valid = 1'b0;
    check($sformatf("v%0d resp_valid", id), 32'(bus.resp_valid), 32'(v.exp_ack));
    check($sformatf("v%0d rdata", id),      bus.resp_rdata,      v.exp_rdata);
    check($sformatf("v%0d err", id),        32'(bus.resp_err),   32'h0);
    @(negedge clk);
    check($sformatf("v%0d resp_once", id),  32'(bus.resp_valid), 32'h0);
    check($sformatf("v%0d idle", id),       32'(bus.busy),       32'h0);
  endtask

  initial begin
    bit got;
    int pulses;

    //              req    we     a0     a1     wd0            wd1            rr rw dly hdata          ack    rd  addr   wdata          rdata
    vecs[0]  = mk(2'b01, 2'b00, 5'd5,  5'd0,  32'h0,         32'h0,         1, 1, 2, 32'hDEADBEEF, 2'b01, 1, 5'd5,  32'h0,         32'hDEADBEEF);
    vecs[1]  = mk(2'b10, 2'b10, 5'd0,  5'd3,  32'h0,         32'h00001234,  1, 1, 1, 32'hFFFFFFFF, 2'b10, 0, 5'd3,  32'h00001234,  32'h0);
    vecs[2]  = mk(2'b11, 2'b00, 5'd7,  5'd9,  32'h0,         32'h0,         1, 1, 1, 32'h11110000, 2'b01, 1, 5'd7,  32'h0,         32'h11110000);
    vecs[3]  = mk(2'b11, 2'b00, 5'd7,  5'd9,  32'h0,         32'h0,         1, 1, 3, 32'h22220000, 2'b10, 1, 5'd9,  32'h0,         32'h22220000);
    vecs[4]  = mk(2'b11, 2'b00, 5'd7,  5'd9,  32'h0,         32'h0,         1, 1, 1, 32'h33330000, 2'b01, 1, 5'd7,  32'h0,         32'h33330000);
    vecs[5]  = mk(2'b11, 2'b00, 5'd7,  5'd9,  32'h0,         32'h0,         1, 1, 2, 32'h44440000, 2'b10, 1, 5'd9,  32'h0,         32'h44440000);
    vecs[6]  = mk(2'b11, 2'b01, 5'd12, 5'd20, 32'hA5A5A5A5,  32'h0,         1, 0, 1, 32'h55550000, 2'b10, 1, 5'd20, 32'h0,         32'h55550000);
    vecs[7]  = mk(2'b01, 2'b01, 5'd12, 5'd20, 32'hA5A5A5A5,  32'h0,         1, 1, 2, 32'h66660000, 2'b01, 0, 5'd12, 32'hA5A5A5A5,  32'h0);
    vecs[8]  = mk(2'b01, 2'b00, 5'd31, 5'd0,  32'h0,         32'h0,         1, 1, 8, 32'h77770000, 2'b01, 1, 5'd31, 32'h0,         32'h77770000);
    vecs[9]  = mk(2'b01, 2'b00, 5'd2,  5'd0,  32'h0,         32'h0,         1, 1, 1, 32'h88880000, 2'b01, 1, 5'd2,  32'h0,         32'h88880000);
    vecs[10] = mk(2'b11, 2'b00, 5'd4,  5'd6,  32'h0,         32'h0,         1, 1, 1, 32'h99990000, 2'b01, 1, 5'd4,  32'h0,         32'h99990000);

    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rd_ready = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = '0;
    bus.wr_ready = 1'b0; bus.wr_valid = 1'b0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Load, store, fairness 0,1,0,1, skip of a blocked store, wrap scan, valid on last WAIT cycle.
    for (int i = 0; i <= 8; i++) run_vec(i, vecs[i]);

    // Timeout: read handler never answers; response on the cycle after the 8th WAIT cycle.
    bus.req = 2'b01; bus.req_we = 2'b00; bus.req_addr = {5'd0, 5'd10};
    bus.rd_ready = 1'b1; bus.rd_data = 32'hBAD0BAD0;
    wait_ack(got);
    check("to ack_seen", 32'(got), 32'h1);
    check("to ack", 32'(bus.req_ack), 32'h1);
    bus.req = '0;
    pulses = 0;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) pulses++;
    end
    check("to early_resp", 32'(pulses), 32'h0);
    check("to busy_wait", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("to resp_valid", 32'(bus.resp_valid), 32'h1);
    check("to err", 32'(bus.resp_err), 32'h1);
    check("to rdata", bus.resp_rdata, 32'h0);
    // A late valid after the abort must be dropped.
    bus.rd_valid = 1'b1;
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (n == 1) bus.rd_valid = 1'b0;
      if ((bus.resp_valid != '0) || (bus.req_ack != '0)) pulses++;
    end
    check("to late_valid", 32'(pulses), 32'h0);
    check("to idle", 32'(bus.busy), 32'h0);
    run_vec(9, vecs[9]);

    // Reset while requester 1's load is in WAIT; rr pointer was 1 and must return to 0.
    bus.req = 2'b10; bus.req_we = 2'b00; bus.req_addr = {5'd8, 5'd0}; bus.rd_ready = 1'b1;
    wait_ack(got);
    check("rst ack_seen", 32'(got), 32'h1);
    check("rst ack", 32'(bus.req_ack), 32'h2);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    bus.rd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.rd_valid = 1'b0;
      if (bus.resp_valid != '0) pulses++;
    end
    check("rst no_resp", 32'(pulses), 32'h0);
    run_vec(10, vecs[10]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
